// File: rtl/pipeline_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: masks cache requests, latches early
// cache responses while the other side still stalls, and keeps saturating perf counters.
module pipeline_ctrl #(
  parameter int CNT_W = 32,
  parameter int XLEN  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             forward_stall,
  input  logic             br_mispredict,
  input  logic             icache_read,
  input  logic             icache_resp,
  input  logic [XLEN-1:0]  icache_rdata,
  input  logic             dcache_read,
  input  logic             dcache_write,
  input  logic             dcache_resp,
  input  logic [XLEN-1:0]  dcache_rdata,
  output logic             icache_read_o,
  output logic             dcache_read_o,
  output logic             dcache_write_o,
  output logic [XLEN-1:0]  fetch_rdata,
  output logic [XLEN-1:0]  mem_rdata,
  output logic             load_pc,
  output logic             load_ifid,
  output logic             load_idex,
  output logic             load_exmem,
  output logic             load_memwb,
  output logic             flush_ifid,
  output logic             flush_idex,
  input  logic             counter_clear,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic [CNT_W-1:0] imem_stall_cnt,
  output logic [CNT_W-1:0] dmem_stall_cnt,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  logic            r_imem_done, r_dmem_done;
  logic [XLEN-1:0] r_ibuf, r_dbuf;
  logic            w_imem_wait, w_dmem_wait, w_advance, w_bubble, w_flush;

  assign icache_read_o  = icache_read  & ~r_imem_done;
  assign dcache_read_o  = dcache_read  & ~r_dmem_done;
  assign dcache_write_o = dcache_write & ~r_dmem_done;

  assign w_imem_wait = icache_read & ~icache_resp & ~r_imem_done;
  assign w_dmem_wait = (dcache_read | dcache_write) & ~dcache_resp & ~r_dmem_done;
  assign w_advance   = ~w_imem_wait & ~w_dmem_wait;
  // A load-use bubble wins over a redirect: the branch operands in EX are not valid yet.
  assign w_bubble    = w_advance & forward_stall;
  assign w_flush     = w_advance & ~forward_stall & br_mispredict;

  assign fetch_rdata = r_imem_done ? r_ibuf : icache_rdata;
  assign mem_rdata   = r_dmem_done ? r_dbuf : dcache_rdata;

  always_comb begin
    load_pc    = 1'b0;
    load_ifid  = 1'b0;
    load_idex  = 1'b0;
    load_exmem = 1'b0;
    load_memwb = 1'b0;
    flush_ifid = 1'b0;
    flush_idex = 1'b0;
    if (w_bubble) begin
      load_idex  = 1'b1;
      flush_idex = 1'b1;
      load_exmem = 1'b1;
      load_memwb = 1'b1;
    end else if (w_advance) begin
      load_pc    = 1'b1;
      load_ifid  = 1'b1;
      load_idex  = 1'b1;
      load_exmem = 1'b1;
      load_memwb = 1'b1;
      flush_ifid = w_flush;
      flush_idex = w_flush;
    end
  end

  // Hold a response that arrived early so the access is not reissued while the other side stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_imem_done <= 1'b0;
      r_dmem_done <= 1'b0;
      r_ibuf      <= '0;
      r_dbuf      <= '0;
    end else if (w_advance) begin
      r_imem_done <= 1'b0;
      r_dmem_done <= 1'b0;
    end else begin
      if (icache_read & icache_resp & ~r_imem_done) begin
        r_imem_done <= 1'b1;
        r_ibuf      <= icache_rdata;
      end
      if ((dcache_read | dcache_write) & dcache_resp & ~r_dmem_done) begin
        r_dmem_done <= 1'b1;
        r_dbuf      <= dcache_rdata;
      end
    end
  end

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && (v != '1)) ? v + 1'b1 : v;
  endfunction

  always_ff @(posedge clk) begin
    if (rst || counter_clear) begin
      cyc_cnt        <= '0;
      imem_stall_cnt <= '0;
      dmem_stall_cnt <= '0;
      bubble_cnt     <= '0;
      flush_cnt      <= '0;
    end else begin
      cyc_cnt        <= sat_inc(cyc_cnt, 1'b1);
      imem_stall_cnt <= sat_inc(imem_stall_cnt, w_imem_wait);
      dmem_stall_cnt <= sat_inc(dmem_stall_cnt, w_dmem_wait);
      bubble_cnt     <= sat_inc(bubble_cnt, w_bubble);
      flush_cnt      <= sat_inc(flush_cnt, w_flush);
    end
  end

endmodule
